// File: rtl/octet_pkg.sv
// Shared types and constants for the Octet operand-buffer sequencer.
package octet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_COMPUTE    = 3'd2,
    ST_DRAIN      = 3'd3,
    ST_WRITE_BACK = 3'd4
  } state_e;

  localparam int ACC_LAT_MAX = 4;

  // Index width for a counter over n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/octet_acc_delay.sv
// Fixed-latency shift line carrying {valid, address} from C read to C write-back.
module octet_acc_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] in_word,
  output logic [W-1:0] out_word,
  output logic         pending
);

  logic [W-1:0] line_q [DEPTH];
  logic [W-1:0] line_d [DEPTH];

  always_comb begin
    line_d[0] = flush ? '0 : in_word;
    for (int i = 1; i < DEPTH; i++) begin
      line_d[i] = flush ? '0 : line_q[i-1];
    end
  end

  // NOTE: this is a handful of flops, not a RAM, so every stage is reset;
  // a stale valid bit here would fire a spurious C write after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= line_d[i];
    end
  end

  assign out_word = line_q[DEPTH-1];

  // Work still in flight behind the output stage (input is idle while draining).
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      pending = pending | line_q[i][W-1];
    end
  end

endmodule

// File: rtl/octet_controller_gen.sv
// Octet sequencer: fetch into A/B/C buffers, compute passes, accumulator drain, C write-back.
module octet_controller_gen
  import octet_pkg::*;
#(
  parameter int A_DEPTH  = 2,
  parameter int B_DEPTH  = 4,
  parameter int NUM_SETS = 4,
  parameter int ACC_LAT  = 1,
  localparam int C_DEPTH = A_DEPTH * B_DEPTH,
  localparam int AW      = idx_width(A_DEPTH),
  localparam int BW      = idx_width(B_DEPTH),
  localparam int CW      = idx_width(C_DEPTH),
  localparam int SETW    = idx_width(NUM_SETS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          fetch_valid,
  input  logic          buffer_ready,
  input  logic          wb_ready,
  output logic          idle,
  output logic          fetch,
  output logic          compute,
  output logic          write_back,
  output logic          done,
  output logic          wb_valid,
  output logic          a_wr_en,
  output logic          a_rd_en,
  output logic [AW-1:0] a_wr_addr,
  output logic [AW-1:0] a_rd_addr,
  output logic          b_wr_en,
  output logic          b_rd_en,
  output logic [BW-1:0] b_wr_addr,
  output logic [BW-1:0] b_rd_addr,
  output logic          c_wr_en,
  output logic          c_rd_en,
  output logic [CW-1:0] c_wr_addr,
  output logic [CW-1:0] c_rd_addr
);

  localparam int LAT = (ACC_LAT < 1) ? 1 : ((ACC_LAT > ACC_LAT_MAX) ? ACC_LAT_MAX : ACC_LAT);
  localparam logic [CW-1:0]   LAST_IDX = CW'(C_DEPTH - 1);
  localparam logic [SETW-1:0] LAST_SET = SETW'(NUM_SETS - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   fb_q, fb_d;
  logic [CW-1:0]   step_q, step_d;
  logic [SETW-1:0] set_q, set_d;
  logic [CW-1:0]   wb_q, wb_d;
  logic            done_q, done_d;
  logic            wb_valid_q, wb_valid_d;

  logic            flush;
  logic            fetch_beat;
  logic            issue;
  logic            wb_beat;
  logic [CW:0]     pipe_in;
  logic [CW:0]     pipe_out;
  logic            pipe_pending;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d    = state_q;
    fb_d       = fb_q;
    step_d     = step_q;
    set_d      = set_q;
    wb_d       = wb_q;
    done_d     = 1'b0;
    wb_valid_d = 1'b0;
    fetch_beat = 1'b0;
    issue      = 1'b0;
    wb_beat    = 1'b0;
    flush      = abort && (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_FETCH;
          fb_d    = '0;
        end
      end
      ST_FETCH: begin
        fetch_beat = fetch_valid;
        if (fetch_valid) begin
          fb_d = fb_q + CW'(1);
          if (fb_q == LAST_IDX) begin
            state_d = ST_COMPUTE;
            step_d  = '0;
            set_d   = '0;
          end
        end
      end
      ST_COMPUTE: begin
        issue = buffer_ready;
        if (buffer_ready) begin
          step_d = step_q + CW'(1);
          if (step_q == LAST_IDX) begin
            set_d = set_q + SETW'(1);
            if (set_q == LAST_SET) state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!pipe_pending) begin
          state_d = ST_WRITE_BACK;
          wb_d    = '0;
        end
      end
      ST_WRITE_BACK: begin
        wb_beat    = wb_ready;
        wb_valid_d = wb_ready;
        if (wb_ready) begin
          wb_d = wb_q + CW'(1);
          if (wb_q == LAST_IDX) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything: nothing new is issued or reported this cycle.
    if (flush) begin
      state_d    = ST_IDLE;
      done_d     = 1'b0;
      wb_valid_d = 1'b0;
      fetch_beat = 1'b0;
      issue      = 1'b0;
      wb_beat    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      fb_q       <= '0;
      step_q     <= '0;
      set_q      <= '0;
      wb_q       <= '0;
      done_q     <= 1'b0;
      wb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fb_q       <= fb_d;
      step_q     <= step_d;
      set_q      <= set_d;
      wb_q       <= wb_d;
      done_q     <= done_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  assign pipe_in = {issue, step_q};

  octet_acc_delay #(
    .DEPTH (LAT),
    .W     (CW + 1)
  ) u_acc_delay (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_word  (pipe_in),
    .out_word (pipe_out),
    .pending  (pipe_pending)
  );

  assign idle       = (state_q == ST_IDLE);
  assign fetch      = (state_q == ST_FETCH);
  assign compute    = (state_q == ST_COMPUTE) || (state_q == ST_DRAIN);
  assign write_back = (state_q == ST_WRITE_BACK);
  assign done       = done_q;
  assign wb_valid   = wb_valid_q;

  assign a_wr_en   = fetch_beat;
  assign b_wr_en   = fetch_beat;
  assign a_wr_addr = fb_q[AW-1:0];
  assign b_wr_addr = fb_q[BW-1:0];

  // A is indexed by the high bits of the step and B by the low bits, so B sweeps fastest.
  assign a_rd_en   = issue;
  assign b_rd_en   = issue;
  assign a_rd_addr = step_q[CW-1:BW];
  assign b_rd_addr = step_q[BW-1:0];

  assign c_wr_en   = fetch_beat | (pipe_out[CW] & ~flush);
  assign c_wr_addr = (state_q == ST_FETCH) ? fb_q : pipe_out[CW-1:0];
  assign c_rd_en   = issue | wb_beat;
  assign c_rd_addr = (state_q == ST_WRITE_BACK) ? wb_q : step_q;

endmodule

// File: tb/tb_octet_controller_gen.sv
// Directed bench: default instance plus an ACC_LAT=3, 4x4, two-set instance.
module tb_octet_controller_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, fetch_valid = 1'b0, buffer_ready = 1'b0, wb_ready = 1'b0;
  logic sel = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;
  int n_a, n_b, n_c, n_sets, lat;

  always #5 clk = ~clk;

  // Default instance: C_DEPTH=8, AW=1, BW=2, CW=3.
  logic       d0_idle, d0_fetch, d0_compute, d0_write_back, d0_done, d0_wb_valid;
  logic       d0_a_wr_en, d0_a_rd_en, d0_b_wr_en, d0_b_rd_en, d0_c_wr_en, d0_c_rd_en;
  logic [0:0] d0_a_wr_addr, d0_a_rd_addr;
  logic [1:0] d0_b_wr_addr, d0_b_rd_addr;
  logic [2:0] d0_c_wr_addr, d0_c_rd_addr;

  // Second instance: C_DEPTH=16, AW=2, BW=2, CW=4.
  logic       d1_idle, d1_fetch, d1_compute, d1_write_back, d1_done, d1_wb_valid;
  logic       d1_a_wr_en, d1_a_rd_en, d1_b_wr_en, d1_b_rd_en, d1_c_wr_en, d1_c_rd_en;
  logic [1:0] d1_a_wr_addr, d1_a_rd_addr;
  logic [1:0] d1_b_wr_addr, d1_b_rd_addr;
  logic [3:0] d1_c_wr_addr, d1_c_rd_addr;

  octet_controller_gen dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .fetch_valid(fetch_valid),
    .buffer_ready(buffer_ready), .wb_ready(wb_ready),
    .idle(d0_idle), .fetch(d0_fetch), .compute(d0_compute), .write_back(d0_write_back),
    .done(d0_done), .wb_valid(d0_wb_valid),
    .a_wr_en(d0_a_wr_en), .a_rd_en(d0_a_rd_en), .a_wr_addr(d0_a_wr_addr), .a_rd_addr(d0_a_rd_addr),
    .b_wr_en(d0_b_wr_en), .b_rd_en(d0_b_rd_en), .b_wr_addr(d0_b_wr_addr), .b_rd_addr(d0_b_rd_addr),
    .c_wr_en(d0_c_wr_en), .c_rd_en(d0_c_rd_en), .c_wr_addr(d0_c_wr_addr), .c_rd_addr(d0_c_rd_addr)
  );

  octet_controller_gen #(.A_DEPTH(4), .B_DEPTH(4), .NUM_SETS(2), .ACC_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .fetch_valid(fetch_valid),
    .buffer_ready(buffer_ready), .wb_ready(wb_ready),
    .idle(d1_idle), .fetch(d1_fetch), .compute(d1_compute), .write_back(d1_write_back),
    .done(d1_done), .wb_valid(d1_wb_valid),
    .a_wr_en(d1_a_wr_en), .a_rd_en(d1_a_rd_en), .a_wr_addr(d1_a_wr_addr), .a_rd_addr(d1_a_rd_addr),
    .b_wr_en(d1_b_wr_en), .b_rd_en(d1_b_rd_en), .b_wr_addr(d1_b_wr_addr), .b_rd_addr(d1_b_rd_addr),
    .c_wr_en(d1_c_wr_en), .c_rd_en(d1_c_rd_en), .c_wr_addr(d1_c_wr_addr), .c_rd_addr(d1_c_rd_addr)
  );

  // Observed signals of whichever instance is under test.
  logic       m_idle, m_fetch, m_compute, m_write_back, m_done, m_wb_valid;
  logic       m_a_wr_en, m_a_rd_en, m_b_wr_en, m_b_rd_en, m_c_wr_en, m_c_rd_en;
  logic [3:0] m_a_wr_addr, m_a_rd_addr, m_b_wr_addr, m_b_rd_addr, m_c_wr_addr, m_c_rd_addr;

  assign m_idle       = sel ? d1_idle       : d0_idle;
  assign m_fetch      = sel ? d1_fetch      : d0_fetch;
  assign m_compute    = sel ? d1_compute    : d0_compute;
  assign m_write_back = sel ? d1_write_back : d0_write_back;
  assign m_done       = sel ? d1_done       : d0_done;
  assign m_wb_valid   = sel ? d1_wb_valid   : d0_wb_valid;
  assign m_a_wr_en    = sel ? d1_a_wr_en    : d0_a_wr_en;
  assign m_a_rd_en    = sel ? d1_a_rd_en    : d0_a_rd_en;
  assign m_b_wr_en    = sel ? d1_b_wr_en    : d0_b_wr_en;
  assign m_b_rd_en    = sel ? d1_b_rd_en    : d0_b_rd_en;
  assign m_c_wr_en    = sel ? d1_c_wr_en    : d0_c_wr_en;
  assign m_c_rd_en    = sel ? d1_c_rd_en    : d0_c_rd_en;
  assign m_a_wr_addr  = sel ? 4'(d1_a_wr_addr) : 4'(d0_a_wr_addr);
  assign m_a_rd_addr  = sel ? 4'(d1_a_rd_addr) : 4'(d0_a_rd_addr);
  assign m_b_wr_addr  = sel ? 4'(d1_b_wr_addr) : 4'(d0_b_wr_addr);
  assign m_b_rd_addr  = sel ? 4'(d1_b_rd_addr) : 4'(d0_b_rd_addr);
  assign m_c_wr_addr  = sel ? 4'(d1_c_wr_addr) : 4'(d0_c_wr_addr);
  assign m_c_rd_addr  = sel ? 4'(d1_c_rd_addr) : 4'(d0_c_rd_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d cycle %0d): got=%0d expected=%0d", tag, sel, cyc_no, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then sit at the falling edge to observe.
  task automatic cyc(input logic st, input logic fv, input logic br, input logic wr, input logic ab);
    @(posedge clk);
    #1;
    start = st; fetch_valid = fv; buffer_ready = br; wb_ready = wr; abort = ab;
    @(negedge clk);
    cyc_no++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0; fetch_valid = 1'b0; buffer_ready = 1'b0; wb_ready = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.idle", m_idle, 1);
    check("rst.fetch", m_fetch, 0);
    check("rst.compute", m_compute, 0);
    check("rst.write_back", m_write_back, 0);
    check("rst.done", m_done, 0);
    check("rst.wb_valid", m_wb_valid, 0);
    check("rst.enables", {m_a_wr_en, m_a_rd_en, m_b_wr_en, m_b_rd_en, m_c_wr_en, m_c_rd_en}, 0);
    check("rst.addrs", {m_a_wr_addr, m_a_rd_addr, m_b_wr_addr, m_b_rd_addr, m_c_wr_addr, m_c_rd_addr}, 0);
    rst = 1'b1;
    cyc_no = 0;
  endtask

  // One job against a per-cycle expectation built from the bench's own stimulus.
  task automatic run_job(input int fv_toggle, input int stall_at, input int stall_len,
                         input logic [31:0] wb_low, input int abort_at);
    int beats, t, n, k, stalled, exp_w;
    logic fv, br, ab, wr, prev_rd;
    int hist [256];

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("start.idle", m_idle, 1);

    // Fetch: start is held high when toggling to show it is ignored outside IDLE.
    beats = 0; t = 0;
    while (beats < n_c) begin
      fv = (fv_toggle == 0) || (t % 2 == 0);
      cyc(fv_toggle != 0, fv, 1'b0, 1'b0, 1'b0);
      check("fetch.state", m_fetch, 1);
      check("fetch.a_wr_en", m_a_wr_en, fv);
      check("fetch.b_wr_en", m_b_wr_en, fv);
      check("fetch.c_wr_en", m_c_wr_en, fv);
      if (fv) begin
        check("fetch.a_wr_addr", m_a_wr_addr, beats % n_a);
        check("fetch.b_wr_addr", m_b_wr_addr, beats % n_b);
        check("fetch.c_wr_addr", m_c_wr_addr, beats);
        beats++;
      end
      t++;
    end

    // Compute: hist[] remembers each cycle's issued C address (-1 for a bubble).
    n = 0; k = 0; stalled = 0;
    while (n < n_sets * n_c) begin
      br = 1'b1;
      if (n == stall_at && stalled < stall_len) begin
        br = 1'b0;
        stalled++;
      end
      ab = (n == abort_at);
      cyc(1'b0, 1'b0, br, 1'b0, ab);
      check("compute.state", m_compute, 1);
      if (ab) begin
        for (int i = 0; i < lat + 2; i++) begin
          cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
          check("abort.idle", m_idle, 1);
          check("abort.c_wr_en", m_c_wr_en, 0);
          check("abort.c_rd_en", m_c_rd_en, 0);
          check("abort.done", m_done, 0);
          check("abort.wb_valid", m_wb_valid, 0);
        end
        return;
      end
      exp_w = (k >= lat) ? hist[k-lat] : -1;
      check("compute.a_rd_en", m_a_rd_en, br);
      check("compute.b_rd_en", m_b_rd_en, br);
      check("compute.c_rd_en", m_c_rd_en, br);
      if (br) begin
        check("compute.c_rd_addr", m_c_rd_addr, n % n_c);
        check("compute.a_rd_addr", m_a_rd_addr, (n % n_c) / n_b);
        check("compute.b_rd_addr", m_b_rd_addr, n % n_b);
      end
      check("compute.c_wr_en", m_c_wr_en, exp_w >= 0);
      if (exp_w >= 0) check("compute.c_wr_addr", m_c_wr_addr, exp_w);
      hist[k] = br ? (n % n_c) : -1;
      if (br) n++;
      k++;
    end

    // Drain: no reads even with buffer_ready high, delayed writes keep coming.
    for (int d = 0; d < lat; d++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_w = hist[k-lat];
      check("drain.compute", m_compute, 1);
      check("drain.write_back", m_write_back, 0);
      check("drain.c_rd_en", m_c_rd_en, 0);
      check("drain.a_rd_en", m_a_rd_en, 0);
      check("drain.c_wr_en", m_c_wr_en, exp_w >= 0);
      if (exp_w >= 0) check("drain.c_wr_addr", m_c_wr_addr, exp_w);
      k++;
    end

    // Write-back: wb_valid trails the accepted read by one cycle.
    beats = 0; t = 0; prev_rd = 1'b0;
    while (beats < n_c) begin
      wr = ~wb_low[t];
      cyc(1'b0, 1'b0, 1'b0, wr, 1'b0);
      check("wb.state", m_write_back, 1);
      check("wb.c_rd_en", m_c_rd_en, wr);
      if (wr) check("wb.c_rd_addr", m_c_rd_addr, beats);
      check("wb.wb_valid", m_wb_valid, prev_rd);
      check("wb.done", m_done, 0);
      check("wb.c_wr_en", m_c_wr_en, 0);
      prev_rd = wr;
      if (wr) beats++;
      t++;
    end

    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("end.idle", m_idle, 1);
    check("end.done", m_done, 1);
    check("end.wb_valid", m_wb_valid, 1);
    check("end.c_rd_en", m_c_rd_en, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("after.done", m_done, 0);
    check("after.wb_valid", m_wb_valid, 0);
    check("after.idle", m_idle, 1);
  endtask

  initial begin
    sel = 1'b0; n_a = 2; n_b = 4; n_c = 8; n_sets = 4; lat = 1;
    do_reset();
    run_job(0, -1, 0, 32'h0, -1);    // back-to-back: done lands 50 cycles after start
    run_job(1, -1, 0, 32'h0, -1);    // fetch_valid toggling, start held during fetch
    run_job(0, 19, 3, 32'h0, -1);    // 3-cycle stall in set 2
    run_job(0, -1, 0, 32'h24, -1);   // wb_ready low on write-back cycles 2 and 5
    run_job(0, -1, 0, 32'h0, 5);     // abort at compute step 5
    run_job(0, -1, 0, 32'h0, -1);    // restart after abort

    // start together with abort in IDLE must not launch a job.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("start_abort.idle", m_idle, 1);
    check("start_abort.fetch", m_fetch, 0);

    // Asynchronous reset in the middle of fetch takes effect before the next edge.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_rst.fetch", m_fetch, 1);
    #1 rst = 1'b0;
    #1;
    check("async_rst.idle", m_idle, 1);
    check("async_rst.fetch", m_fetch, 0);
    check("async_rst.a_wr_en", m_a_wr_en, 0);
    check("async_rst.c_wr_addr", m_c_wr_addr, 0);
    @(negedge clk);
    rst = 1'b1;

    sel = 1'b1; n_a = 4; n_b = 4; n_c = 16; n_sets = 2; lat = 3;
    do_reset();
    run_job(0, -1, 0, 32'h0, -1);
    run_job(0, -1, 0, 32'h24, -1);
    run_job(0, 9, 2, 32'h0, -1);
    run_job(0, -1, 0, 32'h0, 5);
    run_job(1, -1, 0, 32'h0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
